// File: rtl/bfly2_pipe.sv
// bfly2_pipe: three-stage pipelined radix-2 DIT butterfly (y0 = x0 + w*x1, y1 = x0 - w*x1).
// Define BFLY2_PIPE_SAT_EN to saturate out-of-range results; otherwise they wrap to OW bits.
module bfly2_pipe #(
  parameter int DW = 8,
  parameter int TW = 8,
  parameter int OW = DW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] xr0,
  input  logic signed [DW-1:0] xi0,
  input  logic signed [DW-1:0] xr1,
  input  logic signed [DW-1:0] xi1,
  input  logic signed [TW-1:0] wr,
  input  logic signed [TW-1:0] wi,
  input  logic                 inv,
  input  logic                 scale,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] yr0,
  output logic signed [OW-1:0] yi0,
  output logic signed [OW-1:0] yr1,
  output logic signed [OW-1:0] yi1,
  output logic                 ovf,
  input  logic                 ovf_clr
);

  localparam int PW  = DW + TW;
  localparam int SW  = DW + TW + 1;
  localparam int TRW = DW + 2;
  localparam int YW  = DW + 3;
  localparam logic signed [SW-1:0] RND = {{(SW-1){1'b0}}, 1'b1} << (TW - 2);

  // (v + 1) >>> 1 computed one bit wider so the increment can never wrap.
  function automatic logic signed [YW-1:0] halve_rnd(input logic signed [YW-1:0] v);
    logic signed [YW:0] t;
    t = {v[YW-1], v} + {{YW{1'b0}}, 1'b1};
    halve_rnd = t[YW:1];
  endfunction

  function automatic logic fits_ow(input logic signed [YW-1:0] v);
    fits_ow = (&v[YW-1:OW-1]) | ~(|v[YW-1:OW-1]);
  endfunction

  function automatic logic signed [OW-1:0] clip_ow(input logic signed [YW-1:0] v);
`ifdef BFLY2_PIPE_SAT_EN
    if (fits_ow(v)) begin
      clip_ow = v[OW-1:0];
    end else if (v[YW-1]) begin
      clip_ow = {1'b1, {(OW-1){1'b0}}};
    end else begin
      clip_ow = {1'b0, {(OW-1){1'b1}}};
    end
`else
    clip_ow = v[OW-1:0];
`endif
  endfunction

  logic en_s;

  logic                 v1_r, inv_1_r, scale_1_r;
  logic signed [PW-1:0] p_rr_r, p_ir_r, p_ri_r, p_ii_r;
  logic signed [DW-1:0] xr0_1_r, xi0_1_r;
  logic signed [PW-1:0] m_rr_s, m_ir_s, m_ri_s, m_ii_s;

  logic                  v2_r, scale_2_r;
  logic signed [TRW-1:0] tr_2_r, ti_2_r;
  logic signed [DW-1:0]  xr0_2_r, xi0_2_r;
  logic signed [SW-1:0]  tr_s, ti_s, tr_rnd_s, ti_rnd_s;
  logic                  rnd_unused_s;

  logic signed [YW-1:0] y0r_s, y0i_s, y1r_s, y1i_s;
  logic signed [YW-1:0] y0r_sc_s, y0i_sc_s, y1r_sc_s, y1i_sc_s;
  logic                 ovf_any_s;

  // A full output register that is not being drained freezes every stage.
  assign en_s     = out_ready | ~out_valid;
  assign in_ready = en_s;

  assign m_rr_s = PW'(xr1) * PW'(wr);
  assign m_ir_s = PW'(xi1) * PW'(wr);
  assign m_ri_s = PW'(xr1) * PW'(wi);
  assign m_ii_s = PW'(xi1) * PW'(wi);

  // Stage 1: capture full-width partial products plus x0 and sideband.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r      <= 1'b0;
      inv_1_r   <= 1'b0;
      scale_1_r <= 1'b0;
      p_rr_r    <= {PW{1'b0}};
      p_ir_r    <= {PW{1'b0}};
      p_ri_r    <= {PW{1'b0}};
      p_ii_r    <= {PW{1'b0}};
      xr0_1_r   <= {DW{1'b0}};
      xi0_1_r   <= {DW{1'b0}};
    end else if (en_s) begin
      v1_r <= in_valid;
      if (in_valid) begin
        inv_1_r   <= inv;
        scale_1_r <= scale;
        p_rr_r    <= m_rr_s;
        p_ir_r    <= m_ir_s;
        p_ri_r    <= m_ri_s;
        p_ii_r    <= m_ii_s;
        xr0_1_r   <= xr0;
        xi0_1_r   <= xi0;
      end
    end
  end

  // Conjugation negates the wi products, never wi itself, so wi = -1.0 stays exact.
  always_comb begin
    tr_s = {SW{1'b0}};
    ti_s = {SW{1'b0}};
    if (inv_1_r) begin
      tr_s = SW'(p_rr_r) + SW'(p_ii_r);
      ti_s = SW'(p_ir_r) - SW'(p_ri_r);
    end else begin
      tr_s = SW'(p_rr_r) - SW'(p_ii_r);
      ti_s = SW'(p_ir_r) + SW'(p_ri_r);
    end
  end

  assign tr_rnd_s     = tr_s + RND;
  assign ti_rnd_s     = ti_s + RND;
  assign rnd_unused_s = ^{tr_rnd_s[TW-2:0], ti_rnd_s[TW-2:0]};

  // Stage 2: register the rounded twiddle product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r      <= 1'b0;
      scale_2_r <= 1'b0;
      tr_2_r    <= {TRW{1'b0}};
      ti_2_r    <= {TRW{1'b0}};
      xr0_2_r   <= {DW{1'b0}};
      xi0_2_r   <= {DW{1'b0}};
    end else if (en_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        scale_2_r <= scale_1_r;
        tr_2_r    <= tr_rnd_s[SW-1:TW-1];
        ti_2_r    <= ti_rnd_s[SW-1:TW-1];
        xr0_2_r   <= xr0_1_r;
        xi0_2_r   <= xi0_1_r;
      end
    end
  end

  // Stage 3 arithmetic: full-width sums, optional halving, range check.
  always_comb begin
    y0r_s = YW'(xr0_2_r) + YW'(tr_2_r);
    y0i_s = YW'(xi0_2_r) + YW'(ti_2_r);
    y1r_s = YW'(xr0_2_r) - YW'(tr_2_r);
    y1i_s = YW'(xi0_2_r) - YW'(ti_2_r);
    if (scale_2_r) begin
      y0r_sc_s = halve_rnd(y0r_s);
      y0i_sc_s = halve_rnd(y0i_s);
      y1r_sc_s = halve_rnd(y1r_s);
      y1i_sc_s = halve_rnd(y1i_s);
    end else begin
      y0r_sc_s = y0r_s;
      y0i_sc_s = y0i_s;
      y1r_sc_s = y1r_s;
      y1i_sc_s = y1i_s;
    end
    ovf_any_s = ~(fits_ow(y0r_sc_s) & fits_ow(y0i_sc_s) &
                  fits_ow(y1r_sc_s) & fits_ow(y1i_sc_s));
  end

  // Stage 3: output registers and the sticky overflow flag (a new overflow beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      yr0       <= {OW{1'b0}};
      yi0       <= {OW{1'b0}};
      yr1       <= {OW{1'b0}};
      yi1       <= {OW{1'b0}};
      ovf       <= 1'b0;
    end else begin
      if (en_s) begin
        out_valid <= v2_r;
        if (v2_r) begin
          yr0 <= clip_ow(y0r_sc_s);
          yi0 <= clip_ow(y0i_sc_s);
          yr1 <= clip_ow(y1r_sc_s);
          yi1 <= clip_ow(y1i_sc_s);
        end
      end
      ovf <= (ovf & ~ovf_clr) | (en_s & v2_r & ovf_any_s);
    end
  end

endmodule

// File: tb/tb_bfly2_pipe.sv
// Directed self-checking bench for bfly2_pipe: an OW=9 instance and an OW=8 instance
// share all inputs; the OW=8 one exercises overflow / saturation / wrap.
`timescale 1ns/1ps
module tb_bfly2_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic inv = 1'b0;
  logic scale = 1'b0;
  logic ovf_clr = 1'b0;
  logic signed [7:0] xr0 = 8'sd0, xi0 = 8'sd0, xr1 = 8'sd0, xi1 = 8'sd0;
  logic signed [7:0] wr = 8'sd0, wi = 8'sd0;

  logic in_ready, out_valid, ovf;
  logic signed [8:0] yr0, yi0, yr1, yi1;
  logic in_ready8, out_valid8, ovf8;
  logic signed [7:0] y8r0, y8i0, y8r1, y8i1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bfly2_pipe #(.DW(8), .TW(8), .OW(9)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .xr0(xr0), .xi0(xi0), .xr1(xr1), .xi1(xi1), .wr(wr), .wi(wi),
    .inv(inv), .scale(scale), .out_valid(out_valid), .out_ready(out_ready),
    .yr0(yr0), .yi0(yi0), .yr1(yr1), .yi1(yi1), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  bfly2_pipe #(.DW(8), .TW(8), .OW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .xr0(xr0), .xi0(xi0), .xr1(xr1), .xi1(xi1), .wr(wr), .wi(wi),
    .inv(inv), .scale(scale), .out_valid(out_valid8), .out_ready(out_ready),
    .yr0(y8r0), .yi0(y8i0), .yr1(y8r1), .yi1(y8i1), .ovf(ovf8), .ovf_clr(ovf_clr)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] pk9(input int a, input int b, input int c, input int d);
    return {9'(a), 9'(b), 9'(c), 9'(d)};
  endfunction

  function automatic logic [31:0] pk8(input int a, input int b, input int c, input int d);
    return {8'(a), 8'(b), 8'(c), 8'(d)};
  endfunction

  task automatic set_x(input int ar0, input int ai0, input int ar1, input int ai1,
                       input int awr, input int awi);
    xr0 = 8'(ar0); xi0 = 8'(ai0); xr1 = 8'(ar1); xi1 = 8'(ai1);
    wr  = 8'(awr); wi  = 8'(awi);
  endtask

  // One transaction with out_ready held high; checks latency, OW=9 data and ovf.
  task automatic run_one(input int ar0, input int ai0, input int ar1, input int ai1,
                         input int awr, input int awi, input logic ainv, input logic ascale,
                         input string tag, input logic [35:0] exp9, input logic exp_ovf,
                         output logic [31:0] o8, output logic ov8);
    int lat;
    @(negedge clk);
    set_x(ar0, ai0, ar1, ai1, awr, awi);
    inv = ainv; scale = ascale; out_ready = 1'b1; in_valid = 1'b1;
    #1 check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'd3);
    check_eq({tag, "_y"}, 64'({yr0, yi0, yr1, yi1}), 64'(exp9));
    check_eq({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
    o8  = {y8r0, y8i0, y8r1, y8i1};
    ov8 = ovf8;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] o8;
    logic        ov8;
    logic [35:0] exp_s [6];
    int          sent;
    int          got;

    // Reset state
    #2 rst_n = 1'b0;
    #2;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_ovf", 64'(ovf), 64'd0);
    check_eq("rst_y", 64'({yr0, yi0, yr1, yi1}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // Basic butterfly, then w = -j forward and inverse
    run_one(5, -3, 10, 0, 127, 0, 1'b0, 1'b0, "t1", pk9(15, -3, -5, -3), 1'b0, o8, ov8);
    run_one(0, 0, 10, 4, 0, -128, 1'b0, 1'b0, "t2_fwd", pk9(4, -10, -4, 10), 1'b0, o8, ov8);
    run_one(0, 0, 10, 4, 0, -128, 1'b1, 1'b0, "t2_inv", pk9(-4, 10, 4, -10), 1'b0, o8, ov8);

    // Overflow in the OW=8 instance only
    run_one(127, 127, 127, 0, 127, 0, 1'b0, 1'b0, "t3", pk9(253, 127, 1, 127), 1'b0, o8, ov8);
`ifdef BFLY2_PIPE_SAT_EN
    check_eq("t3_ow8_y", 64'(o8), 64'(pk8(127, 127, 1, 127)));
`else
    check_eq("t3_ow8_y", 64'(o8), 64'(pk8(-3, 127, 1, 127)));
`endif
    check_eq("t3_ow8_ovf", 64'(ov8), 64'd1);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    #1 check_eq("t3_ovf_clr", 64'(ovf8), 64'd0);

    // Clear coinciding with a new overflow load leaves ovf set
    @(negedge clk);
    set_x(127, 127, 127, 0, 127, 0); inv = 1'b0; scale = 1'b0; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    #1;
    check_eq("t3_clr_vs_set_valid", 64'(out_valid8), 64'd1);
    check_eq("t3_clr_vs_set_ovf", 64'(ovf8), 64'd1);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    #1 check_eq("t3_ovf_clr2", 64'(ovf8), 64'd0);

    // Scaled version fits in both widths
    run_one(127, 127, 127, 0, 127, 0, 1'b0, 1'b1, "t4", pk9(127, 64, 1, 64), 1'b0, o8, ov8);
    check_eq("t4_ow8_y", 64'(o8), 64'(pk8(127, 64, 1, 64)));
    check_eq("t4_ow8_ovf", 64'(ov8), 64'd0);

    // Overflow at OW=9: y0r = 127 + 255 = 382
`ifdef BFLY2_PIPE_SAT_EN
    run_one(127, 0, -128, -128, -128, 127, 1'b0, 1'b0, "ovf9", pk9(255, 1, -128, -1), 1'b1, o8, ov8);
`else
    run_one(127, 0, -128, -128, -128, 127, 1'b0, 1'b0, "ovf9", pk9(-130, 1, -128, -1), 1'b1, o8, ov8);
`endif

    // Streaming with backpressure in cycles 2..7
    for (int k = 1; k <= 6; k++) exp_s[k-1] = pk9(10*k + 10, k, 10*k - 10, k);
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 2 && cyc <= 7);
      if (sent < 6) begin
        set_x(10*(sent+1), sent+1, 10, 0, 127, 0);
        inv = 1'b0; scale = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 3 && cyc <= 7) check_eq("t5_in_ready_stall", 64'(in_ready), 64'd0);
      if (out_valid) begin
        check_eq("t5_y", 64'({yr0, yi0, yr1, yi1}), 64'(exp_s[got]));
        if (out_ready) got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    check_eq("t5_count", 64'(got), 64'd6);
    repeat (4) begin
      @(negedge clk);
      #1 check_eq("t5_no_dup", 64'(out_valid), 64'd0);
    end

    // Reset with three in flight, ovf still set from ovf9
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      set_x(i, 0, 10, 0, 127, 0); in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    check_eq("t6_pre_valid", 64'(out_valid), 64'd1);
    check_eq("t6_pre_ovf", 64'(ovf), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", 64'(out_valid), 64'd0);
    check_eq("t6_rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_one(5, -3, 10, 0, 127, 0, 1'b0, 1'b0, "t6", pk9(15, -3, -5, -3), 1'b0, o8, ov8);
    repeat (3) begin
      @(negedge clk);
      #1 check_eq("t6_no_stale", 64'(out_valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
